// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifq_pkg;

    localparam int IFQ_VA    = 16;   // virtual address width; PCs are [VA-1:1]
    localparam int IFQ_DEPTH = 4;    // default FIFO depth

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HALT    = 2'd2,
        DISCARD = 2'd3
    } ifq_state_t;

    // Queue entry at the default address width.
    typedef struct packed {
        logic [15:0]        ins;
        logic [IFQ_VA-2:0]  pc;
        logic               fault;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Generic DEPTH-entry synchronous FIFO with push/pop/clear and occupancy count.
// Latency: a pushed word is visible on o_rdat the cycle after the push.
// Backpressure: none internal; caller must never push when full (asserted).
//
// Ports: i_clk, i_rst_n (async active-low), i_clear (drops all entries),
//        i_push/i_wdat, i_pop (ignored when empty), o_rdat (head word),
//        o_empty, o_count (0..DEPTH).
module ifq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            // Clear beats any same-cycle push or pop.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdat  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    a_no_push_when_full: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_clear && (r_count == FULL_C))
    );

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches halfwords ahead of execute, flushes/refetches on redirect.
// Latency: first mem_req 1 cycle after reset/redirect; returned data on ins_* 1 cycle after mem_done.
// Backpressure: credit-based - a fetch is only in flight when the FIFO has room for its response.
//
// Ports: clk, reset_n (async active-low); redirect/redirect_pc (flush + new PC);
//        mem_req/mem_addr -> memory, mem_done/mem_rdata/mem_fault <- memory;
//        ins_valid/ins/ins_pc/ins_fault -> consumer, ins_take <- consumer; level = occupancy.
// Optional: define IFQ_BYPASS_EN to forward a response combinationally to ins_* when the FIFO is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int             VA       = IFQ_VA,
    parameter int             DEPTH    = IFQ_DEPTH,
    parameter logic [VA-2:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     redirect,
    input  logic [VA-2:0]            redirect_pc,
    output logic                     mem_req,
    output logic [VA-2:0]            mem_addr,
    input  logic                     mem_done,
    input  logic [15:0]              mem_rdata,
    input  logic                     mem_fault,
    output logic                     ins_valid,
    output logic [15:0]              ins,
    output logic [VA-2:0]            ins_pc,
    output logic                     ins_fault,
    input  logic                     ins_take,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [VA-2:0] PC_ONE  = {{(VA-2){1'b0}}, 1'b1};

    typedef struct packed {
        logic [15:0]    ins;
        logic [VA-2:0]  pc;
        logic           fault;
    } entry_t;

    ifq_state_t     r_state;
    ifq_state_t     w_state_nxt;
    logic [VA-2:0]  r_fetch_pc;
    logic [VA-2:0]  w_fetch_pc_nxt;
    logic [VA-2:0]  r_mem_addr;
    logic           r_mem_req;

    logic           w_done;
    logic           w_push_ok;
    logic           w_push;
    logic           w_pop;
    logic           w_credit;
    logic           w_fifo_empty;
    logic [CW-1:0]  w_level;
    logic [CW-1:0]  w_level_nxt;
    entry_t         w_wdat;
    entry_t         w_head;

    // A strobe only means something while a request is actually outstanding.
    assign w_done    = mem_done && r_mem_req;
    // Only responses to live requests in REQ are kept; DISCARD and redirect drop them.
    assign w_push_ok = (r_state == REQ) && w_done && !redirect;
    assign w_pop     = ins_take && !w_fifo_empty && !redirect;
    assign w_wdat    = entry_t'{ins: mem_rdata, pc: r_fetch_pc, fault: mem_fault};

`ifdef IFQ_BYPASS_EN
    logic w_bypass;

    assign w_bypass  = w_push_ok && w_fifo_empty;
    // A bypassed word that is consumed immediately never occupies a slot.
    assign w_push    = w_push_ok && !(w_bypass && ins_take);
    assign ins_valid = !w_fifo_empty || w_bypass;
    assign ins       = w_bypass ? mem_rdata  : w_head.ins;
    assign ins_pc    = w_bypass ? r_mem_addr : w_head.pc;
    assign ins_fault = w_bypass ? mem_fault  : w_head.fault;
`else
    assign w_push    = w_push_ok;
    assign ins_valid = !w_fifo_empty;
    assign ins       = w_head.ins;
    assign ins_pc    = w_head.pc;
    assign ins_fault = w_head.fault;
`endif

    // Occupancy after this edge; a new request is only allowed if its response
    // is guaranteed a free slot, so REQ always implies level < DEPTH.
    assign w_level_nxt = w_level + CW'(w_push) - CW'(w_pop);
    assign w_credit    = (w_level_nxt < DEPTH_C);

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect) begin
            w_fetch_pc_nxt = redirect_pc;
            // An unanswered request must still be absorbed before refetching.
            w_state_nxt    = (r_mem_req && !mem_done) ? DISCARD : REQ;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_credit) w_state_nxt = REQ;
                end
                REQ: begin
                    if (w_done) begin
                        if (mem_fault) begin
                            w_state_nxt = HALT;
                        end else begin
                            w_fetch_pc_nxt = r_fetch_pc + PC_ONE;
                            w_state_nxt    = w_credit ? REQ : IDLE;
                        end
                    end
                end
                HALT: begin
                    w_state_nxt = HALT;
                end
                DISCARD: begin
                    if (w_done) w_state_nxt = REQ;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_req  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            // The address of a request being discarded must stay stable until its strobe.
            if (w_state_nxt != DISCARD) begin
                r_mem_addr <= w_fetch_pc_nxt;
            end
            r_mem_req  <= (w_state_nxt == REQ) || (w_state_nxt == DISCARD);
        end
    end

    ifq_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clear (redirect),
        .i_push  (w_push),
        .i_wdat  (w_wdat),
        .i_pop   (w_pop),
        .o_rdat  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_level)
    );

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign level    = w_level;

endmodule
